// File: rtl/id40048008_conv_pkg.sv
// Shared encodings for the parametrised 1-D convolution core.
package id40048008_conv_pkg;

  typedef enum logic [1:0] {
    MODE_FULL  = 2'b00,
    MODE_VALID = 2'b01,
    MODE_SAME  = 2'b10,
    MODE_RSVD  = 2'b11
  } mode_e;

  localparam int CFG_SX_LSB   = 0;
  localparam int CFG_SY_LSB   = 16;
  localparam int CFG_MODE_LSB = 29;
  localparam int CFG_SAT_BIT  = 31;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ERR,
    S_SETUP,
    S_MAC,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_e;

endpackage

// File: rtl/id40048008_conv_if.sv
// Control/status and memory-port bundle between the AIP wrapper, its memories and the core.
interface id40048008_conv_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic                     start;
  logic [31:0]              config_in;
  logic signed [DATA_W-1:0] dataX;
  logic [ADDR_W-1:0]        memX_addr;
  logic signed [DATA_W-1:0] dataY;
  logic [ADDR_W-1:0]        memY_addr;
  logic signed [DATA_W-1:0] dataZ;
  logic [ADDR_W:0]          memZ_addr;
  logic                     writeZ;
  logic                     busy_out;
  logic                     done_out;
  logic                     err_out;

  modport slave (
    input  start, config_in, dataX, dataY,
    output memX_addr, memY_addr, dataZ, memZ_addr, writeZ, busy_out, done_out, err_out
  );

  modport master (
    output start, config_in, dataX, dataY,
    input  memX_addr, memY_addr, dataZ, memZ_addr, writeZ, busy_out, done_out, err_out
  );
endinterface

// File: rtl/id40048008_mac_pipe.sv
// Product register + accumulator + output shift/saturate for one output sample.
module id40048008_mac_pipe #(
  parameter  int DATA_W    = 32,
  parameter  int ADDR_W    = 5,
  parameter  int OUT_SHIFT = 0,
  localparam int ACC_W     = 2*DATA_W + ADDR_W
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic                     sat_en,
  output logic signed [ACC_W-1:0]  acc_out,
  output logic signed [DATA_W-1:0] z_out
);

  localparam logic signed [ACC_W-1:0] ZMAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ZMIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  // vld_pipe[0]: read data present on a/b; vld_pipe[1]: product register holds a term
  logic [1:0]                 vld_pipe;
  logic signed [2*DATA_W-1:0] w_ax, w_bx, w_prod, r_prod;
  logic signed [ACC_W-1:0]    r_acc, w_sh;

  assign w_ax   = {{DATA_W{a[DATA_W-1]}}, a};
  assign w_bx   = {{DATA_W{b[DATA_W-1]}}, b};
  assign w_prod = w_ax * w_bx;

  // Track issued address pairs through the read and multiply stages
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) vld_pipe <= '0;
    else       vld_pipe <= {vld_pipe[0], en};
  end

  // Multiply stage, then accumulate; clr starts a fresh output sample
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_prod <= '0;
      r_acc  <= '0;
    end else begin
      if (vld_pipe[0]) r_prod <= w_prod;
      if (clr)              r_acc <= '0;
      else if (vld_pipe[1]) r_acc <= r_acc + {{ADDR_W{r_prod[2*DATA_W-1]}}, r_prod};
    end
  end

  assign acc_out = r_acc;
  assign w_sh    = r_acc >>> OUT_SHIFT;

  // Narrow to DATA_W: clamp when saturating, otherwise keep the low bits
  always_comb begin
    z_out = w_sh[DATA_W-1:0];
    if (sat_en) begin
      if (w_sh > ZMAX)      z_out = ZMAX[DATA_W-1:0];
      else if (w_sh < ZMIN) z_out = ZMIN[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/id40048008_conv_core_v2.sv
// 1-D signed convolution engine: FSM, n/k counters, kmin/kmax and memory addressing.
module id40048008_conv_core_v2
  import id40048008_conv_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int OUT_SHIFT = 0
) (
  input logic clk,
  input logic rstn,
  id40048008_conv_if.slave bus
);

  // n can reach sx+sy-1 (n+1), so two extra bits over the address width
  localparam int NW    = ADDR_W + 2;
  localparam int ACC_W = 2*DATA_W + ADDR_W;
  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  state_e            r_state, w_next;
  logic [ADDR_W:0]   r_sx, r_sy;
  mode_e             r_mode;
  logic              r_sat, r_err, r_dcnt;
  logic [NW-1:0]     r_n;
  logic [ADDR_W-1:0] r_k, r_kmax;
  logic [ADDR_W:0]   r_zaddr, r_zlast;

  logic [NW-1:0] w_sx, w_sy, w_n1, w_kmin, w_kmax, w_nstart, w_zlast, w_ydiff;
  logic          w_cfg_err, w_k_last, w_z_last, w_write, w_unused;
  logic signed [ACC_W-1:0]  w_acc;
  logic signed [DATA_W-1:0] w_z;

  assign w_sx     = NW'(r_sx);
  assign w_sy     = NW'(r_sy);
  assign w_n1     = r_n + NW'(1);
  assign w_kmin   = (w_n1 > w_sy) ? w_n1 - w_sy : '0;
  assign w_kmax   = (r_n < w_sx - NW'(1)) ? r_n : w_sx - NW'(1);
  assign w_ydiff  = r_n - NW'(r_k);
  assign w_k_last = (r_k == r_kmax);
  assign w_z_last = (r_zaddr == r_zlast);

  // Reject empty/oversized operands, the reserved mode and VALID with sx < sy
  always_comb begin
    w_cfg_err = 1'b0;
    if (r_sx == '0 || r_sy == '0)         w_cfg_err = 1'b1;
    if (r_sx > MAX_LEN || r_sy > MAX_LEN) w_cfg_err = 1'b1;
    if (r_mode == MODE_RSVD)              w_cfg_err = 1'b1;
    if (r_mode == MODE_VALID && r_sx < r_sy) w_cfg_err = 1'b1;
  end

  // First n of the run and the Z address of its last output
  always_comb begin
    w_nstart = '0;
    w_zlast  = w_sx + w_sy - NW'(2);
    case (r_mode)
      MODE_VALID: begin
        w_nstart = w_sy - NW'(1);
        w_zlast  = w_sx - w_sy;
      end
      MODE_SAME: begin
        w_nstart = (w_sy - NW'(1)) >> 1;
        w_zlast  = w_sx - NW'(1);
      end
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; start is only honoured from IDLE
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_CHECK;
      S_CHECK: w_next = w_cfg_err ? S_ERR : S_SETUP;
      S_ERR:   w_next = S_IDLE;
      S_SETUP: w_next = S_MAC;
      S_MAC:   if (w_k_last) w_next = S_DRAIN;
      S_DRAIN: if (r_dcnt) w_next = S_WRITE;
      S_WRITE: w_next = w_z_last ? S_DONE : S_SETUP;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Config latch, n/k/Z counters and drain timer
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sx    <= '0;
      r_sy    <= '0;
      r_mode  <= MODE_FULL;
      r_sat   <= 1'b0;
      r_err   <= 1'b0;
      r_n     <= '0;
      r_k     <= '0;
      r_kmax  <= '0;
      r_zaddr <= '0;
      r_zlast <= '0;
      r_dcnt  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_sx   <= bus.config_in[CFG_SX_LSB +: ADDR_W+1];
          r_sy   <= bus.config_in[CFG_SY_LSB +: ADDR_W+1];
          r_mode <= mode_e'(bus.config_in[CFG_MODE_LSB +: 2]);
          r_sat  <= bus.config_in[CFG_SAT_BIT];
          r_err  <= 1'b0;
        end
        S_CHECK: begin
          r_err   <= w_cfg_err;
          r_n     <= w_nstart;
          r_zlast <= w_zlast[ADDR_W:0];
          r_zaddr <= '0;
        end
        S_SETUP: begin
          r_k    <= w_kmin[ADDR_W-1:0];
          r_kmax <= w_kmax[ADDR_W-1:0];
          r_dcnt <= 1'b0;
        end
        S_MAC:   if (!w_k_last) r_k <= r_k + ADDR_W'(1);
        S_DRAIN: r_dcnt <= 1'b1;
        S_WRITE: begin
          r_n     <= r_n + NW'(1);
          r_zaddr <= r_zaddr + (ADDR_W+1)'(1);
        end
        default: ;
      endcase
    end
  end

  id40048008_mac_pipe #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .OUT_SHIFT(OUT_SHIFT)
  ) u_mac (
    .clk    (clk),
    .rstn   (rstn),
    .clr    (r_state == S_SETUP),
    .en     (r_state == S_MAC),
    .a      (bus.dataX),
    .b      (bus.dataY),
    .sat_en (r_sat),
    .acc_out(w_acc),
    .z_out  (w_z)
  );

  assign w_write       = (r_state == S_WRITE);
  assign bus.memX_addr = r_k;
  assign bus.memY_addr = w_ydiff[ADDR_W-1:0];
  assign bus.memZ_addr = r_zaddr;
  assign bus.writeZ    = w_write;
  assign bus.dataZ     = w_write ? w_z : '0;
  assign bus.busy_out  = r_state inside {S_CHECK, S_SETUP, S_MAC, S_DRAIN, S_WRITE};
  assign bus.done_out  = (r_state == S_DONE) || (r_state == S_ERR);
  assign bus.err_out   = r_err;

  // Field gaps in config_in and headroom bits of the index arithmetic
  assign w_unused = ^{bus.config_in, w_ydiff[NW-1:ADDR_W], w_kmin[NW-1:ADDR_W],
                      w_kmax[NW-1:ADDR_W], w_zlast[NW-1:ADDR_W+1], w_acc};

endmodule

// File: tb/tb_id40048008_conv_core_v2.sv
// Directed bench: three core builds (32-bit, 8-bit, 8-bit with OUT_SHIFT=8).
module tb_id40048008_conv_core_v2;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  id40048008_conv_if #(.DATA_W(32), .ADDR_W(5)) ifa ();
  id40048008_conv_if #(.DATA_W(8),  .ADDR_W(5)) ifb ();
  id40048008_conv_if #(.DATA_W(8),  .ADDR_W(5)) ifc ();

  id40048008_conv_core_v2 #(.DATA_W(32), .ADDR_W(5), .OUT_SHIFT(0)) u_a (.clk(clk), .rstn(rstn), .bus(ifa));
  id40048008_conv_core_v2 #(.DATA_W(8),  .ADDR_W(5), .OUT_SHIFT(0)) u_b (.clk(clk), .rstn(rstn), .bus(ifb));
  id40048008_conv_core_v2 #(.DATA_W(8),  .ADDR_W(5), .OUT_SHIFT(8)) u_c (.clk(clk), .rstn(rstn), .bus(ifc));

  int memX [32];
  int memY [32];
  logic sa = 1'b0, sbc = 1'b0;
  logic [31:0] cfg_a = '0, cfg_bc = '0;

  assign ifa.start = sa;  assign ifa.config_in = cfg_a;
  assign ifb.start = sbc; assign ifb.config_in = cfg_bc;
  assign ifc.start = sbc; assign ifc.config_in = cfg_bc;

  // Input memories with one cycle of read latency
  always @(posedge clk) begin
    ifa.dataX <= memX[ifa.memX_addr];
    ifa.dataY <= memY[ifa.memY_addr];
    ifb.dataX <= 8'(memX[ifb.memX_addr]);
    ifb.dataY <= 8'(memY[ifb.memY_addr]);
    ifc.dataX <= 8'(memX[ifc.memX_addr]);
    ifc.dataY <= 8'(memY[ifc.memY_addr]);
  end

  int za[$], zaa[$], zb[$], zba[$], zc[$], zca[$];
  int done_a = 0, done_b = 0, done_c = 0, busy_a = 0;

  // Output memory capture and event counters
  always @(negedge clk) begin
    if (ifa.writeZ) begin za.push_back(int'(ifa.dataZ)); zaa.push_back(int'(ifa.memZ_addr)); end
    if (ifb.writeZ) begin zb.push_back(int'(ifb.dataZ)); zba.push_back(int'(ifb.memZ_addr)); end
    if (ifc.writeZ) begin zc.push_back(int'(ifc.dataZ)); zca.push_back(int'(ifc.memZ_addr)); end
    if (ifa.done_out) done_a++;
    if (ifb.done_out) done_b++;
    if (ifc.done_out) done_c++;
    if (ifa.busy_out) busy_a++;
  end

  int nvec = 0, nerr = 0;
  int ba, bda, bba, bb, bc, bdb, bdc;

  function automatic logic [31:0] mk(input int sx, input int sy, input int md, input int sat);
    mk = {sat[0], md[1:0], 13'(sy), 16'(sx)};
  endfunction

  function automatic int at(input int q[$], input int i);
    at = (i < q.size()) ? q[i] : -999;
  endfunction

  task automatic go_a(input logic [31:0] c, output bit to);
    ba = za.size(); bda = done_a; bba = busy_a;
    @(negedge clk); cfg_a = c; sa = 1'b1;
    @(negedge clk); sa = 1'b0; cfg_a = 32'hFFFF_FFFF;
    to = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (done_a != bda) begin to = 1'b0; break; end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic go_bc(input logic [31:0] c, output bit to);
    bb = zb.size(); bc = zc.size(); bdb = done_b; bdc = done_c;
    @(negedge clk); cfg_bc = c; sbc = 1'b1;
    @(negedge clk); sbc = 1'b0; cfg_bc = 32'hFFFF_FFFF;
    to = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (done_b != bdb && done_c != bdc) begin to = 1'b0; break; end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    nvec++;
    if ({ifa.busy_out, ifa.done_out, ifa.err_out, ifa.writeZ} !== 4'b0) begin
      nerr++; $display("FAIL reset_ctl: got %b want 0000", {ifa.busy_out, ifa.done_out, ifa.err_out, ifa.writeZ});
    end
    nvec++;
    if ({ifa.memX_addr, ifa.memY_addr, ifa.memZ_addr, ifa.dataZ} !== '0) begin
      nerr++; $display("FAIL reset_bus: got %h want 0", {ifa.memX_addr, ifa.memY_addr, ifa.memZ_addr, ifa.dataZ});
    end
    rstn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_full();
    int exp[4] = '{1, 3, 5, 3};
    bit to;
    memX[0] = 1; memX[1] = 2; memX[2] = 3; memY[0] = 1; memY[1] = 1;
    go_a(mk(3, 2, 0, 0), to);
    nvec++; if (to !== 1'b0) begin nerr++; $display("FAIL full_timeout: no done_out, want done"); end
    nvec++; if (za.size() - ba !== 4) begin nerr++; $display("FAIL full_count: got %0d writes want 4", za.size() - ba); end
    for (int i = 0; i < 4; i++) begin
      nvec++;
      if (at(za, ba+i) !== exp[i] || at(zaa, ba+i) !== i) begin
        nerr++; $display("FAIL full_z%0d: got %0d@%0d want %0d@%0d", i, at(za, ba+i), at(zaa, ba+i), exp[i], i);
      end
    end
    nvec++; if (done_a - bda !== 1) begin nerr++; $display("FAIL full_done: got %0d pulses want 1", done_a - bda); end
    nvec++; if (ifa.err_out !== 1'b0) begin nerr++; $display("FAIL full_err: got %b want 0", ifa.err_out); end
    nvec++; if (busy_a - bba !== 23) begin nerr++; $display("FAIL full_busy: got %0d cycles want 23", busy_a - bba); end
  endtask

  task automatic test_valid();
    int exp[2] = '{3, 5};
    bit to;
    memX[0] = 1; memX[1] = 2; memX[2] = 3; memY[0] = 1; memY[1] = 1;
    go_a(mk(3, 2, 1, 0), to);
    nvec++; if (to !== 1'b0 || za.size() - ba !== 2) begin nerr++; $display("FAIL valid_count: got %0d writes (timeout %b) want 2", za.size() - ba, to); end
    for (int i = 0; i < 2; i++) begin
      nvec++;
      if (at(za, ba+i) !== exp[i] || at(zaa, ba+i) !== i) begin
        nerr++; $display("FAIL valid_z%0d: got %0d@%0d want %0d@%0d", i, at(za, ba+i), at(zaa, ba+i), exp[i], i);
      end
    end
    go_a(mk(2, 3, 1, 0), to);
    nvec++; if (ifa.err_out !== 1'b1) begin nerr++; $display("FAIL valid_err: got %b want 1", ifa.err_out); end
    nvec++; if (to !== 1'b0 || done_a - bda !== 1) begin nerr++; $display("FAIL valid_err_done: got %0d pulses want 1", done_a - bda); end
    nvec++; if (za.size() - ba !== 0) begin nerr++; $display("FAIL valid_err_writes: got %0d want 0", za.size() - ba); end
    nvec++; if (busy_a - bba !== 1) begin nerr++; $display("FAIL valid_err_busy: got %0d cycles want 1", busy_a - bba); end
  endtask

  task automatic test_same();
    int exp[4] = '{3, 6, 9, 7};
    bit to;
    for (int i = 0; i < 4; i++) memX[i] = i + 1;
    for (int i = 0; i < 3; i++) memY[i] = 1;
    go_a(mk(4, 3, 2, 0), to);
    nvec++; if (to !== 1'b0 || za.size() - ba !== 4) begin nerr++; $display("FAIL same_count: got %0d writes (timeout %b) want 4", za.size() - ba, to); end
    for (int i = 0; i < 4; i++) begin
      nvec++;
      if (at(za, ba+i) !== exp[i] || at(zaa, ba+i) !== i) begin
        nerr++; $display("FAIL same_z%0d: got %0d@%0d want %0d@%0d", i, at(za, ba+i), at(zaa, ba+i), exp[i], i);
      end
    end
  endtask

  task automatic test_narrow();
    int eb_sat[3] = '{127, 127, 127};
    int ec_sat[3] = '{39, 78, 39};
    int eb_wrp[3] = '{16, 32, 16};
    int eb_neg[3] = '{-128, 0, 127};
    int ec_neg[3] = '{-40, 0, 39};
    bit to;
    memX[0] = 100; memX[1] = 100; memY[0] = 100; memY[1] = 100;
    go_bc(mk(2, 2, 0, 1), to);
    nvec++; if (to !== 1'b0 || zb.size() - bb !== 3 || zc.size() - bc !== 3) begin
      nerr++; $display("FAIL nar_sat_count: got %0d/%0d writes want 3/3", zb.size() - bb, zc.size() - bc); end
    for (int i = 0; i < 3; i++) begin
      nvec++;
      if (at(zb, bb+i) !== eb_sat[i] || at(zc, bc+i) !== ec_sat[i] || at(zba, bb+i) !== i) begin
        nerr++; $display("FAIL nar_sat_z%0d: got %0d/%0d want %0d/%0d", i, at(zb, bb+i), at(zc, bc+i), eb_sat[i], ec_sat[i]);
      end
    end
    go_bc(mk(2, 2, 0, 0), to);
    for (int i = 0; i < 3; i++) begin
      nvec++;
      if (at(zb, bb+i) !== eb_wrp[i]) begin
        nerr++; $display("FAIL nar_wrap_z%0d: got %0d want %0d", i, at(zb, bb+i), eb_wrp[i]);
      end
    end
    memX[0] = -100;
    go_bc(mk(2, 2, 0, 1), to);
    for (int i = 0; i < 3; i++) begin
      nvec++;
      if (at(zb, bb+i) !== eb_neg[i] || at(zc, bc+i) !== ec_neg[i]) begin
        nerr++; $display("FAIL nar_neg_z%0d: got %0d/%0d want %0d/%0d", i, at(zb, bb+i), at(zc, bc+i), eb_neg[i], ec_neg[i]);
      end
    end
  endtask

  task automatic test_cfg_err();
    bit to;
    go_a(mk(0, 2, 0, 0), to);
    nvec++; if (ifa.err_out !== 1'b1 || za.size() - ba !== 0 || done_a - bda !== 1) begin
      nerr++; $display("FAIL err_sx0: got err=%b writes=%0d done=%0d want 1/0/1", ifa.err_out, za.size() - ba, done_a - bda); end
    go_a(mk(3, 2, 3, 0), to);
    nvec++; if (ifa.err_out !== 1'b1 || za.size() - ba !== 0 || done_a - bda !== 1) begin
      nerr++; $display("FAIL err_mode3: got err=%b writes=%0d done=%0d want 1/0/1", ifa.err_out, za.size() - ba, done_a - bda); end
    go_a(mk(33, 2, 0, 0), to);
    nvec++; if (ifa.err_out !== 1'b1 || za.size() - ba !== 0) begin
      nerr++; $display("FAIL err_sx33: got err=%b writes=%0d want 1/0", ifa.err_out, za.size() - ba); end
    // largest legal length; y={1} so z mirrors x
    for (int i = 0; i < 32; i++) memX[i] = 7*i - 100;
    memY[0] = 1;
    go_a(mk(32, 1, 0, 0), to);
    nvec++; if (ifa.err_out !== 1'b0) begin nerr++; $display("FAIL err_clear: got %b want 0", ifa.err_out); end
    nvec++; if (to !== 1'b0 || za.size() - ba !== 32) begin nerr++; $display("FAIL max_count: got %0d writes want 32", za.size() - ba); end
    for (int i = 0; i < 32; i++) begin
      nvec++;
      if (at(za, ba+i) !== 7*i - 100 || at(zaa, ba+i) !== i) begin
        nerr++; $display("FAIL max_z%0d: got %0d@%0d want %0d@%0d", i, at(za, ba+i), at(zaa, ba+i), 7*i - 100, i);
      end
    end
  endtask

  task automatic test_control();
    int exp[4] = '{1, 3, 5, 3};
    bit to;
    int b0, d0;
    memX[0] = 1; memX[1] = 2; memX[2] = 3; memY[0] = 1; memY[1] = 1;
    ba = za.size(); bda = done_a;
    @(negedge clk); cfg_a = mk(3, 2, 0, 0); sa = 1'b1;
    @(negedge clk); sa = 1'b0; cfg_a = mk(2, 3, 1, 0);
    repeat (3) @(negedge clk);
    sa = 1'b1; @(negedge clk); sa = 1'b0;
    to = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (ifa.done_out) begin to = 1'b0; sa = 1'b1; break; end
    end
    @(negedge clk); sa = 1'b0;
    repeat (10) @(negedge clk);
    nvec++; if (to !== 1'b0 || za.size() - ba !== 4) begin nerr++; $display("FAIL ctl_count: got %0d writes want 4", za.size() - ba); end
    for (int i = 0; i < 4; i++) begin
      nvec++;
      if (at(za, ba+i) !== exp[i] || at(zaa, ba+i) !== i) begin
        nerr++; $display("FAIL ctl_z%0d: got %0d@%0d want %0d@%0d", i, at(za, ba+i), at(zaa, ba+i), exp[i], i);
      end
    end
    nvec++; if (done_a - bda !== 1 || ifa.busy_out !== 1'b0 || ifa.err_out !== 1'b0) begin
      nerr++; $display("FAIL ctl_done: got done=%0d busy=%b err=%b want 1/0/0", done_a - bda, ifa.busy_out, ifa.err_out); end

    // reset in the middle of the first MAC phase
    b0 = za.size(); d0 = done_a;
    @(negedge clk); cfg_a = mk(3, 2, 0, 0); sa = 1'b1;
    @(negedge clk); sa = 1'b0;
    repeat (2) @(negedge clk);
    nvec++; if (ifa.busy_out !== 1'b1) begin nerr++; $display("FAIL rst_prebusy: got %b want 1", ifa.busy_out); end
    rstn = 1'b0; #1;
    nvec++;
    if ({ifa.busy_out, ifa.done_out, ifa.err_out, ifa.writeZ} !== 4'b0 ||
        {ifa.memX_addr, ifa.memY_addr, ifa.memZ_addr, ifa.dataZ} !== '0) begin
      nerr++; $display("FAIL rst_mid: got ctl=%b bus=%h want 0", {ifa.busy_out, ifa.done_out, ifa.err_out, ifa.writeZ},
                       {ifa.memX_addr, ifa.memY_addr, ifa.memZ_addr, ifa.dataZ});
    end
    repeat (2) @(negedge clk); rstn = 1'b1;
    repeat (8) @(negedge clk);
    nvec++; if (za.size() !== b0 || done_a !== d0) begin
      nerr++; $display("FAIL rst_quiet: got %0d writes %0d dones want 0/0", za.size() - b0, done_a - d0); end
    go_a(mk(3, 2, 0, 0), to);
    for (int i = 0; i < 4; i++) begin
      nvec++;
      if (to !== 1'b0 || at(za, ba+i) !== exp[i] || at(zaa, ba+i) !== i) begin
        nerr++; $display("FAIL rst_rerun_z%0d: got %0d@%0d want %0d@%0d", i, at(za, ba+i), at(zaa, ba+i), exp[i], i);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin memX[i] = 0; memY[i] = 0; end
    test_reset();
    test_full();
    test_valid();
    test_same();
    test_narrow();
    test_cfg_err();
    test_control();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
